plru_tree: RTL and testbench

- Parametrised tree pseudo-LRU replacement engine for the set-associative caches. Handles any power-of-two associativity.
- Keeps one (num_ways-1)-bit tree per set and updates it on every access/fill (load).
- On a read, computes the full victim way and registers it for the next cycle.
- Adds two behaviours:
  - invalid-way-first victim selection.
  - same-cycle read/load forwarding, so the cache controller sees a victim that reflects the current access.

---
 rtl/plru_tree_if.sv | 38 +++
 rtl/plru_tree.sv | 97 +++++++++
 tb/tb_plru_tree.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/plru_tree_if.sv
// rtl/plru_tree_if.sv - request/response bundle between a cache controller and the pseudo-LRU engine
interface plru_tree_if #(
    parameter int s_index  = 3,
    parameter int num_ways = 4
);
    localparam int width = $clog2(num_ways);

    logic                 read;
    logic [s_index-1:0]   rindex;
    logic [num_ways-1:0]  valid_in;
    logic                 load;
    logic [s_index-1:0]   windex;
    logic [width-1:0]     recent_block_in;
    logic [width-1:0]     evicted_way_out;
    logic                 victim_invalid_out;

    modport master (
        output read,
        output rindex,
        output valid_in,
        output load,
        output windex,
        output recent_block_in,
        input  evicted_way_out,
        input  victim_invalid_out
    );

    modport slave (
        input  read,
        input  rindex,
        input  valid_in,
        input  load,
        input  windex,
        input  recent_block_in,
        output evicted_way_out,
        output victim_invalid_out
    );
endinterface

// File: rtl/plru_tree.sv
// rtl/plru_tree.sv - tree pseudo-LRU victim engine with invalid-way-first selection and read/load forwarding
module plru_tree #(
    parameter  int s_index  = 3,
    parameter  int num_ways = 4,
    localparam int width    = $clog2(num_ways),
    localparam int num_sets = 2 ** s_index,
    localparam int nodes    = num_ways - 1
) (
    input  logic       clk,
    input  logic       rst,
    plru_tree_if.slave bus
);

    typedef logic [nodes-1:0] tree_t;
    typedef logic [width-1:0] way_t;

    tree_t data [num_sets];

    // Node indices fit in width bits because a tree over num_ways leaves has num_ways-1 nodes.
    function automatic tree_t touch_tree(input tree_t tree, input way_t way);
        tree_t t;
        int    node;
        t = tree;
        for (int i = 0; i < width; i++) begin
            node = (2 ** i) - 1 + int'(way >> (width - i));
            t[way_t'(node)] = ~way[way_t'(width - 1 - i)];
        end
        return t;
    endfunction

    function automatic way_t tree_victim(input tree_t tree);
        way_t v;
        int   node;
        logic b;
        v    = '0;
        node = 0;
        for (int i = 0; i < width; i++) begin
            b = tree[way_t'(node)];
            v[way_t'(width - 1 - i)] = b;
            node = 2 * node + 1 + int'(b);
        end
        return v;
    endfunction

    tree_t datain;
    tree_t rd_tree;
    way_t  inv_way;
    logic  inv_found;
    way_t  victim_next;

    always_comb begin
        datain = touch_tree(data[bus.windex], bus.recent_block_in);
    end

    // A same-set load in this cycle must be visible to the victim computed from it.
    always_comb begin
        rd_tree = data[bus.rindex];
        if (bus.load && (bus.rindex == bus.windex)) begin
            rd_tree = datain;
        end
    end

    // Scanning downward leaves the lowest-numbered invalid way as the winner.
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int i = num_ways - 1; i >= 0; i--) begin
            if (!bus.valid_in[way_t'(i)]) begin
                inv_found = 1'b1;
                inv_way   = way_t'(i);
            end
        end
    end

    always_comb begin
        victim_next = inv_found ? inv_way : tree_victim(rd_tree);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < num_sets; s++) begin
                data[s] <= '0;
            end
            bus.evicted_way_out    <= '0;
            bus.victim_invalid_out <= 1'b0;
        end else begin
            if (bus.load) begin
                data[bus.windex] <= datain;
            end
            if (bus.read) begin
                bus.evicted_way_out    <= victim_next;
                bus.victim_invalid_out <= inv_found;
            end
        end
    end

endmodule

// File: tb/tb_plru_tree.sv
// tb/tb_plru_tree.sv - directed self-checking bench for plru_tree in 4-way and 8-way configurations
module tb_plru_tree;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    plru_tree_if #(.s_index(3), .num_ways(4)) b4 ();
    plru_tree_if #(.s_index(3), .num_ways(8)) b8 ();

    plru_tree #(.s_index(3), .num_ways(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
    plru_tree #(.s_index(3), .num_ways(8)) u8 (.clk(clk), .rst(rst), .bus(b8));

    int vectors    = 0;
    int miscompares = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b4.read = 1'b0; b4.load = 1'b0; b4.rindex = '0; b4.windex = '0;
        b4.valid_in = 4'hF; b4.recent_block_in = '0;
        b8.read = 1'b0; b8.load = 1'b0; b8.rindex = '0; b8.windex = '0;
        b8.valid_in = 8'hFF; b8.recent_block_in = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic load4(input logic [2:0] s, input logic [1:0] w);
        b4.load = 1'b1; b4.windex = s; b4.recent_block_in = w;
        step();
        b4.load = 1'b0;
    endtask

    task automatic read4(input logic [2:0] s, input logic [3:0] v);
        b4.read = 1'b1; b4.rindex = s; b4.valid_in = v;
        step();
        b4.read = 1'b0; b4.valid_in = 4'hF;
    endtask

    task automatic load8(input logic [2:0] s, input logic [2:0] w);
        b8.load = 1'b1; b8.windex = s; b8.recent_block_in = w;
        step();
        b8.load = 1'b0;
    endtask

    task automatic read8(input logic [2:0] s);
        b8.read = 1'b1; b8.rindex = s; b8.valid_in = 8'hFF;
        step();
        b8.read = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (b4.evicted_way_out !== 2'd0 || b4.victim_invalid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got way=%0d inv=%0b want way=0 inv=0",
                     b4.evicted_way_out, b4.victim_invalid_out);
        end
        read4(3'd5, 4'hF);
        vectors++;
        if (b4.evicted_way_out !== 2'd0 || b4.victim_invalid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_read_set5 got way=%0d inv=%0b want way=0 inv=0",
                     b4.evicted_way_out, b4.victim_invalid_out);
        end
    endtask

    task automatic test_update_sequence();
        logic [1:0] ways [3] = '{2'd0, 2'd2, 2'd1};
        logic [1:0] exp  [3] = '{2'd2, 2'd1, 2'd3};
        for (int k = 0; k < 3; k++) begin
            load4(3'd5, ways[k]);
            read4(3'd5, 4'hF);
            vectors++;
            if (b4.evicted_way_out !== exp[k] || b4.victim_invalid_out !== 1'b0) begin
                miscompares++;
                $display("FAIL update_after_way%0d got way=%0d inv=%0b want way=%0d inv=0",
                         ways[k], b4.evicted_way_out, b4.victim_invalid_out, exp[k]);
            end
        end
        read4(3'd3, 4'hF);
        vectors++;
        if (b4.evicted_way_out !== 2'd0 || b4.victim_invalid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL set_independence got way=%0d inv=%0b want way=0 inv=0",
                     b4.evicted_way_out, b4.victim_invalid_out);
        end
    endtask

    task automatic test_invalid_first();
        read4(3'd5, 4'b1011);
        vectors++;
        if (b4.evicted_way_out !== 2'd2 || b4.victim_invalid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL invalid_way2 got way=%0d inv=%0b want way=2 inv=1",
                     b4.evicted_way_out, b4.victim_invalid_out);
        end
        read4(3'd5, 4'b0000);
        vectors++;
        if (b4.evicted_way_out !== 2'd0 || b4.victim_invalid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL invalid_all got way=%0d inv=%0b want way=0 inv=1",
                     b4.evicted_way_out, b4.victim_invalid_out);
        end
    endtask

    task automatic test_forwarding();
        apply_reset();
        b4.load = 1'b1; b4.windex = 3'd5; b4.recent_block_in = 2'd0;
        b4.read = 1'b1; b4.rindex = 3'd5; b4.valid_in = 4'hF;
        step();
        idle();
        vectors++;
        if (b4.evicted_way_out !== 2'd2 || b4.victim_invalid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL forward_same_set got way=%0d inv=%0b want way=2 inv=0",
                     b4.evicted_way_out, b4.victim_invalid_out);
        end
        apply_reset();
        b4.load = 1'b1; b4.windex = 3'd5; b4.recent_block_in = 2'd0;
        b4.read = 1'b1; b4.rindex = 3'd4; b4.valid_in = 4'hF;
        step();
        idle();
        vectors++;
        if (b4.evicted_way_out !== 2'd0 || b4.victim_invalid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL forward_other_set got way=%0d inv=%0b want way=0 inv=0",
                     b4.evicted_way_out, b4.victim_invalid_out);
        end
    endtask

    task automatic test_eight_way();
        for (int w = 0; w < 8; w++) begin
            load8(3'd0, 3'(w));
        end
        read8(3'd0);
        vectors++;
        if (b8.evicted_way_out !== 3'd0 || b8.victim_invalid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL eight_way_sweep got way=%0d inv=%0b want way=0 inv=0",
                     b8.evicted_way_out, b8.victim_invalid_out);
        end
        load8(3'd0, 3'd0);
        read8(3'd0);
        vectors++;
        if (b8.evicted_way_out !== 3'd4 || b8.victim_invalid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL eight_way_touch0 got way=%0d inv=%0b want way=4 inv=0",
                     b8.evicted_way_out, b8.victim_invalid_out);
        end
    endtask

    task automatic test_hold();
        read4(3'd2, 4'b0111);
        vectors++;
        if (b4.evicted_way_out !== 2'd3 || b4.victim_invalid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_setup got way=%0d inv=%0b want way=3 inv=1",
                     b4.evicted_way_out, b4.victim_invalid_out);
        end
        for (int i = 0; i < 10; i++) begin
            b4.read = 1'b0;
            b4.load = 1'b1; b4.windex = 3'(i % 8); b4.recent_block_in = 2'(i % 4);
            b4.rindex = 3'd5; b4.valid_in = 4'h0;
            step();
            vectors++;
            if (b4.evicted_way_out !== 2'd3 || b4.victim_invalid_out !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_cycle%0d got way=%0d inv=%0b want way=3 inv=1",
                         i, b4.evicted_way_out, b4.victim_invalid_out);
            end
        end
        idle();
    endtask

    task automatic test_reset_priority();
        apply_reset();
        load4(3'd5, 2'd0);
        b4.load = 1'b1; b4.windex = 3'd5; b4.recent_block_in = 2'd3;
        b4.read = 1'b1; b4.rindex = 3'd5; b4.valid_in = 4'hF;
        step();
        idle();
        vectors++;
        if (b4.evicted_way_out !== 2'd1 || b4.victim_invalid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_setup got way=%0d inv=%0b want way=1 inv=0",
                     b4.evicted_way_out, b4.victim_invalid_out);
        end
        rst = 1'b1;
        b4.load = 1'b1; b4.windex = 3'd5; b4.recent_block_in = 2'd0;
        b4.read = 1'b1; b4.rindex = 3'd5; b4.valid_in = 4'b1110;
        step();
        vectors++;
        if (b4.evicted_way_out !== 2'd0 || b4.victim_invalid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_during_reset got way=%0d inv=%0b want way=0 inv=0",
                     b4.evicted_way_out, b4.victim_invalid_out);
        end
        rst = 1'b0;
        idle();
        read4(3'd5, 4'hF);
        vectors++;
        if (b4.evicted_way_out !== 2'd0 || b4.victim_invalid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_no_commit got way=%0d inv=%0b want way=0 inv=0",
                     b4.evicted_way_out, b4.victim_invalid_out);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_update_sequence();
        test_invalid_first();
        test_forwarding();
        test_eight_way();
        test_hold();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
